// File: rtl/spike_rate_decoder.sv
// Spike-train to rate decoder: counts rising edges per lane over a programmable
// window and latches the counts into a result bank read through a lane mux.
module spike_rate_decoder #(
  parameter int LANES = 8,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANES-1:0]         spike,
  input  logic [WIN_W-1:0]         win_len,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     cont,
  input  logic [$clog2(LANES)-1:0] sel,
  output logic [CNT_W-1:0]         rate_out,
  output logic                     sat_out,
  output logic                     valid,
  output logic                     busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_nxt;
  logic [LANES-1:0]  spike_q;
  logic [LANES-1:0]  evt;
  logic [WIN_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  acc     [LANES];
  logic [CNT_W-1:0]  acc_nxt [LANES];
  logic [LANES-1:0]  sat, sat_nxt;
  logic [CNT_W-1:0]  result  [LANES];
  logic [LANES-1:0]  res_sat;
  logic              do_load;
  logic              do_finish;

  assign evt = spike & ~spike_q;

  // Per-lane saturating increment; the next values also feed the bank on the
  // last window cycle so that cycle's events are included.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      acc_nxt[i] = acc[i];
      sat_nxt[i] = sat[i];
      if (evt[i]) begin
        if (acc[i] == CNT_MAX) sat_nxt[i] = 1'b1;
        else                   acc_nxt[i] = acc[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // stop has priority over both start and window completion.
  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_finish = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop && (win_len != '0)) begin
          do_load   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (win_cnt == WIN_W'(1)) begin
          do_finish = 1'b1;
          if (cont && (win_len != '0)) do_load   = 1'b1;
          else                         state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // valid is a one-cycle strobe with no ready: the bank changed on the edge
  // just before it, and the bank stays stable until the next strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_q <= '0;
      win_cnt <= '0;
      valid   <= 1'b0;
      sat     <= '0;
      res_sat <= '0;
      for (int i = 0; i < LANES; i++) begin
        acc[i]    <= '0;
        result[i] <= '0;
      end
    end else begin
      spike_q <= spike;
      valid   <= do_finish;
      if (do_load) begin
        win_cnt <= win_len;
        sat     <= '0;
        for (int i = 0; i < LANES; i++) acc[i] <= '0;
      end else if (state == RUN) begin
        win_cnt <= win_cnt - WIN_W'(1);
        sat     <= sat_nxt;
        for (int i = 0; i < LANES; i++) acc[i] <= acc_nxt[i];
      end
      if (do_finish) begin
        res_sat <= sat_nxt;
        for (int i = 0; i < LANES; i++) result[i] <= acc_nxt[i];
      end
    end
  end

  assign busy     = (state == RUN);
  assign rate_out = (int'(sel) < LANES) ? result[sel] : '0;
  assign sat_out  = (int'(sel) < LANES) ? res_sat[sel] : 1'b0;

endmodule
